// File: rtl/cx_mac_requant_if.sv
// Complex valid/ready stream bundle; the slave side carries no tuser.
interface cx_mac_requant_if #(
  parameter int W = 16
);
  logic [W-1:0] tdata_re;
  logic [W-1:0] tdata_im;
  logic         tlast;
  logic [1:0]   tuser;
  logic         tvalid;
  logic         tready;

  modport master (output tdata_re, tdata_im, tlast, tuser, tvalid, input tready);
  modport slave  (input tdata_re, tdata_im, tlast, tvalid, output tready);
endinterface

// File: rtl/cx_mac_requant.sv
// Requantizes complex Q3.37 accumulators to Q1.15 samples: round-half-to-even,
// then saturate, with per-component flags and a saturating overflow counter.
module cx_mac_requant #(
  parameter int IN_W     = 40,
  parameter int IN_FRAC  = 37,
  parameter int OUT_W    = 16,
  parameter int OUT_FRAC = 15,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  cx_mac_requant_if.slave   s_axis,
  cx_mac_requant_if.master  m_axis,
  input  logic              ovf_clr,
  output logic [CNT_W-1:0]  ovf_count
);

  localparam int D  = IN_FRAC - OUT_FRAC;
  localparam int RW = IN_W - D + 1;
  localparam logic [D-1:0]          HALF   = {1'b1, {(D-1){1'b0}}};
  localparam logic signed [RW-1:0]  SAT_HI = RW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [RW-1:0]  SAT_LO = ~SAT_HI;

  // One extra bit of headroom so rounding the largest input up cannot wrap.
  function automatic logic signed [RW-1:0] roundHalfEven(input logic [IN_W-1:0] x);
    logic [IN_W-D-1:0] q;
    logic [D-1:0]      r;
    logic              up;
    q  = x[IN_W-1:D];
    r  = x[D-1:0];
    up = (r > HALF) || ((r == HALF) && q[0]);
    return $signed({q[IN_W-D-1], q}) + $signed({{(RW-1){1'b0}}, up});
  endfunction

  function automatic logic [OUT_W:0] saturate(input logic signed [RW-1:0] v);
    if (v > SAT_HI)
      return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
    else if (v < SAT_LO)
      return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    else
      return {1'b0, v[OUT_W-1:0]};
  endfunction

  logic                 en;
  logic                 s1Valid_q;
  logic signed [RW-1:0] s1Re_q;
  logic signed [RW-1:0] s1Im_q;
  logic                 s1Last_q;

  logic                 mValid_q;
  logic [OUT_W-1:0]     mRe_q;
  logic [OUT_W-1:0]     mIm_q;
  logic                 mLast_q;
  logic [1:0]           mUser_q;
  logic [OUT_W:0]       satRe_d;
  logic [OUT_W:0]       satIm_d;

  logic [CNT_W-1:0]     ovfCount_q;
  logic [CNT_W-1:0]     ovfCount_d;

  assign en            = !mValid_q || m_axis.tready;
  assign s_axis.tready = en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q <= 1'b0;
      s1Re_q    <= '0;
      s1Im_q    <= '0;
      s1Last_q  <= 1'b0;
    end else if (en) begin
      s1Valid_q <= s_axis.tvalid;
      s1Re_q    <= roundHalfEven(s_axis.tdata_re);
      s1Im_q    <= roundHalfEven(s_axis.tdata_im);
      s1Last_q  <= s_axis.tlast;
    end
  end

  always_comb begin
    satRe_d = saturate(s1Re_q);
    satIm_d = saturate(s1Im_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mValid_q <= 1'b0;
      mRe_q    <= '0;
      mIm_q    <= '0;
      mLast_q  <= 1'b0;
      mUser_q  <= 2'b00;
    end else if (en) begin
      mValid_q <= s1Valid_q;
      mRe_q    <= satRe_d[OUT_W-1:0];
      mIm_q    <= satIm_d[OUT_W-1:0];
      mLast_q  <= s1Last_q;
      mUser_q  <= {satIm_d[OUT_W], satRe_d[OUT_W]};
    end
  end

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_comb begin
    ovfCount_d = ovfCount_q;
    if (ovf_clr)
      ovfCount_d = '0;
    else if (mValid_q && m_axis.tready && (mUser_q != 2'b00) && (ovfCount_q != '1))
      ovfCount_d = ovfCount_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovfCount_q <= '0;
    else
      ovfCount_q <= ovfCount_d;
  end

  assign m_axis.tvalid   = mValid_q;
  assign m_axis.tdata_re = mRe_q;
  assign m_axis.tdata_im = mIm_q;
  assign m_axis.tlast    = mLast_q;
  assign m_axis.tuser    = mUser_q;
  assign ovf_count       = ovfCount_q;

endmodule
